// File: rtl/finalproject_soc_keycode_in_pkg.sv
// Shared constants and the STATUS register layout for the keycode input port.
package finalproject_soc_keycode_in_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    // Word addresses on the Avalon slave
    localparam logic [ADDR_W-1:0] ADDR_DATA   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_EN = 2'd2;

    // STATUS bit positions
    localparam int unsigned ST_EMPTY   = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_OVF     = 2;
    localparam int unsigned ST_CNT_LSB = 4;
    localparam int unsigned ST_CNT_W   = 5;

    // STATUS word as seen by software; field order matches the ST_* positions
    typedef struct packed {
        logic [DATA_W-ST_CNT_LSB-ST_CNT_W-1:0] rsvd_hi;
        logic [ST_CNT_W-1:0]                   count;
        logic                                  rsvd_3;
        logic                                  ovf;
        logic                                  full;
        logic                                  empty;
    } status_t;

    // Build the STATUS word with all reserved bits forced to zero
    function automatic logic [DATA_W-1:0] pack_status(
        input logic [ST_CNT_W-1:0] count,
        input logic                ovf,
        input logic                full,
        input logic                empty
    );
        status_t s;
        s         = '0;
        s.count   = count;
        s.ovf     = ovf;
        s.full    = full;
        s.empty   = empty;
        return DATA_W'(s);
    endfunction

endpackage

// File: rtl/finalproject_soc_keycode_fifo.sv
// Small synchronous FIFO holding codes pushed by fabric logic.
//   clk, reset_n : system clock, synchronous active-low reset
//   push, din    : write request and data (ignored when full unless popping)
//   pop          : read request (ignored when empty)
//   dout         : head entry (undefined content when empty; caller gates it)
//   count        : number of stored entries, 0..DEPTH
//   empty, full  : occupancy flags
module finalproject_soc_keycode_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_pop;
    logic             do_push;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(DEPTH));
    assign count = cnt;
    assign dout  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; no reset needed because count guards every read
    always_ff @(posedge clk) begin
        if (reset_n && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/finalproject_soc_keycode_in.sv
// Avalon-MM input port: fabric pushes codes into a FIFO, the CPU pops them.
//   clk, reset_n          : system clock, synchronous active-low reset
//   address, chipselect,
//   read_n, write_n,
//   writedata, readdata   : Avalon-MM slave, zero read latency
//   in_code, in_valid     : one-cycle push strobe from fabric logic
//   irq                   : level interrupt, high while enabled and data is pending
// Register map: 0 DATA (read pops), 1 STATUS (write bit 2 clears overflow),
// 2 IRQ_EN (bit 0), 3 reserved. WIDTH must be <= 8; DEPTH a power of two in 2..16.
module finalproject_soc_keycode_in
    import finalproject_soc_keycode_in_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_code,
    input  logic              in_valid,
    output logic              irq
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;

    logic             rd_access;
    logic             wr_access;
    logic             pop_req;
    logic             pop_ok;
    logic             drop;
    logic             ovf_clr;
    logic             irq_en_we;
    logic             overflow;
    logic             irq_en;
    logic             unused_wdata;

    // Bus strobe decode
    assign rd_access = chipselect & ~read_n;
    assign wr_access = chipselect & ~write_n;
    assign pop_req   = rd_access & (address == ADDR_DATA);
    assign ovf_clr   = wr_access & (address == ADDR_STATUS) & writedata[ST_OVF];
    assign irq_en_we = wr_access & (address == ADDR_IRQ_EN);

    // A code is lost only when the FIFO is full and nothing leaves it this cycle
    assign pop_ok = pop_req & ~fifo_empty;
    assign drop   = in_valid & fifo_full & ~pop_ok;

    finalproject_soc_keycode_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_valid),
        .pop     (pop_req),
        .din     (in_code),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Sticky overflow (set beats clear) and interrupt enable
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (irq_en_we) begin
                irq_en <= writedata[0];
            end
        end
    end

    // Derived only from registered state, so bus activity cannot glitch it
    assign irq = irq_en & ~fifo_empty;

    // Zero-latency read mux; DATA reads as zero while empty
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: begin
                if (!fifo_empty) begin
                    readdata = DATA_W'(fifo_dout);
                end
            end
            ADDR_STATUS: begin
                readdata = pack_status(ST_CNT_W'(fifo_count), overflow, fifo_full, fifo_empty);
            end
            ADDR_IRQ_EN: begin
                readdata = DATA_W'(irq_en);
            end
            default: begin
                readdata = '0;
            end
        endcase
    end

    // Write data bits with no register behind them
    assign unused_wdata = ^{writedata[31:3], writedata[1]};

endmodule

// File: tb/tb_finalproject_soc_keycode_in.sv
module tb_finalproject_soc_keycode_in;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_code;
    logic        in_valid;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_ovf;
    logic       m_irq_en;

    // Scoreboard of expected readdata values
    logic [31:0] sb_q[$];
    string       sb_tag[$];

    finalproject_soc_keycode_in #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_code    (in_code),
        .in_valid   (in_valid),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        int          sz;
        sz = mq.size();
        r  = '0;
        case (a)
            2'd0: if (sz > 0) r = {24'd0, mq[0]};
            2'd1: r = {23'd0, 5'(sz), 1'b0, m_ovf, (sz == 4), (sz == 0)};
            2'd2: r = {31'd0, m_irq_en};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic model_irq();
        return m_irq_en & (mq.size() != 0);
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovf    = 1'b0;
        m_irq_en = 1'b0;
    endfunction

    // One bus/fabric cycle, entered and left at posedge+1.
    // use_exp selects a fixed expected read value instead of the model's.
    task automatic do_cycle(input string tag,
                            input logic push, input logic [7:0] code,
                            input logic rd, input logic wr,
                            input logic [1:0] a, input logic [31:0] wd,
                            input logic use_exp, input logic [31:0] exp);
        logic pop_ok;
        address    = a;
        chipselect = rd | wr;
        read_n     = ~rd;
        write_n    = ~wr;
        writedata  = wd;
        in_code    = code;
        in_valid   = push;
        if (rd) begin
            sb_q.push_back(use_exp ? exp : model_read(a));
            sb_tag.push_back(tag);
        end
        @(negedge clk);
        check({tag, "_irq"}, 32'(irq), 32'(model_irq()));
        if (rd) begin
            check(sb_tag.pop_front(), readdata, sb_q.pop_front());
        end
        // model update for this edge
        pop_ok = rd && (a == 2'd0) && (mq.size() > 0);
        if (pop_ok) void'(mq.pop_front());
        if (wr && a == 2'd1 && wd[2]) m_ovf = 1'b0;
        if (wr && a == 2'd2) m_irq_en = wd[0];
        if (push) begin
            if (mq.size() < 4) mq.push_back(code);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        in_valid   = 1'b0;
    endtask

    task automatic rd_exp(input string tag, input logic [1:0] a, input logic [31:0] exp);
        do_cycle(tag, 1'b0, 8'h00, 1'b1, 1'b0, a, 32'h0, 1'b1, exp);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
        do_cycle("wr", 1'b0, 8'h00, 1'b0, 1'b1, a, wd, 1'b0, 32'h0);
    endtask

    task automatic push(input logic [7:0] code);
        do_cycle("push", 1'b1, code, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic reset_checks();
        rd_exp("rst_data", 2'd0, 32'h0);
        rd_exp("rst_status", 2'd1, 32'h1);
        rd_exp("rst_irqen", 2'd2, 32'h0);
        rd_exp("rst_rsvd", 2'd3, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = '0;
        in_code    = '0;
        in_valid   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        reset_checks();

        // Three pushes, then drain in order
        push(8'h11);
        push(8'h22);
        push(8'h33);
        rd_exp("st3", 2'd1, 32'h30);
        rd_exp("d11", 2'd0, 32'h11);
        rd_exp("d22", 2'd0, 32'h22);
        rd_exp("d33", 2'd0, 32'h33);
        rd_exp("st_empty", 2'd1, 32'h01);
        rd_exp("d_empty", 2'd0, 32'h0);

        // Overflow: fifth push dropped, then sticky bit cleared by software
        push(8'h51);
        push(8'h52);
        push(8'h53);
        push(8'h54);
        push(8'h55);
        rd_exp("st_ovf", 2'd1, 32'h46);
        wr_reg(2'd1, 32'h4);
        rd_exp("st_ovf_clr", 2'd1, 32'h42);
        rd_exp("d51", 2'd0, 32'h51);
        rd_exp("d52", 2'd0, 32'h52);
        rd_exp("d53", 2'd0, 32'h53);
        rd_exp("d54", 2'd0, 32'h54);
        rd_exp("st_after_ovf", 2'd1, 32'h01);

        // Full FIFO with pop and push in the same cycle
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        push(8'hA4);
        do_cycle("full_pp", 1'b1, 8'hAA, 1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 32'hA1);
        rd_exp("st_full_pp", 2'd1, 32'h42);
        rd_exp("dA2", 2'd0, 32'hA2);
        rd_exp("dA3", 2'd0, 32'hA3);
        rd_exp("dA4", 2'd0, 32'hA4);
        rd_exp("dAA", 2'd0, 32'hAA);

        // Empty FIFO with pop and push together: only the push lands
        do_cycle("empty_pp", 1'b1, 8'h3C, 1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 32'h0);
        rd_exp("st_empty_pp", 2'd1, 32'h10);
        rd_exp("d3C", 2'd0, 32'h3C);

        // Overflow set and clear in the same cycle: set wins
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        do_cycle("ovf_race", 1'b1, 8'h05, 1'b0, 1'b1, 2'd1, 32'h4, 1'b0, 32'h0);
        rd_exp("st_ovf_race", 2'd1, 32'h46);
        wr_reg(2'd1, 32'hFFFF_FFFF);
        for (int i = 1; i <= 4; i++) rd_exp("drain", 2'd0, 32'(i));

        // Interrupt timing
        wr_reg(2'd2, 32'h1);
        rd_exp("irqen_rd", 2'd2, 32'h1);
        check("irq_idle", 32'(irq), 32'h0);
        push(8'h7E);
        check("irq_hi", 32'(irq), 32'h1);
        rd_exp("d7E", 2'd0, 32'h7E);
        check("irq_lo", 32'(irq), 32'h0);
        push(8'h7F);
        wr_reg(2'd2, 32'h0);
        check("irq_dis", 32'(irq), 32'h0);
        wr_reg(2'd2, 32'h1);
        check("irq_reen", 32'(irq), 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            logic [1:0] a;
            logic       p, r, w;
            a = 2'($urandom_range(0, 3));
            p = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 2) == 0);
            w = ~r & ($urandom_range(0, 3) == 0);
            do_cycle("rand", p, 8'($urandom), r, w, a, $urandom, 1'b0, 32'h0);
        end

        // Reset in the middle of a push burst
        push(8'hC1);
        push(8'hC2);
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_code  = 8'hC3;
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        model_reset();
        reset_checks();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
